// File: rtl/alu_iter.sv
// alu_iter: RV32I register-register ALU plus RV32M multiply/divide.
// Single-cycle ops complete in the cycle after acceptance; multiply and
// divide iterate one bit per cycle (shift-add / restoring divide).
//
// Handshake: a request is taken on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE and never during reset; in_valid seen while
// in_ready is low is dropped. out_valid is a one-cycle pulse with no
// back-pressure; result/flags hold until the next completion.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             o_state_dbg
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [SHW-1:0]        r_cnt;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_result;
  logic [3:0]            r_flags;
  // Iterative datapath: mul -> r_hi:r_lo is the running product, r_opnd the
  // multiplicand; div -> r_hi is the remainder, r_lo dividend/quotient,
  // r_opnd the divisor. All hold operand magnitudes.
  logic [WIDTH-1:0]      r_hi, r_lo, r_opnd;
  logic [4:0]            r_op;
  logic                  r_neg_q, r_neg_r, r_dz;

  logic                  w_accept, w_is_iter, w_last;
  logic                  w_sub, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]      w_bx, w_ma, w_mb;
  logic [WIDTH:0]        w_sum;
  logic                  w_ovf;
  logic [WIDTH-1:0]      w_simple_res;
  logic [3:0]            w_simple_flg;

  logic                  w_is_mul;
  logic [WIDTH:0]        w_mul_sum, w_div_sh, w_div_tr;
  logic                  w_div_ge;
  logic [WIDTH-1:0]      w_hi_nxt, w_lo_nxt;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_quo, w_rem, w_iter_res;
  logic [3:0]            w_iter_flg;

  assign in_ready    = (r_state == S_IDLE) && !reset;
  assign w_accept    = in_valid && in_ready;
  assign w_is_iter   = (op >= OP_MUL) && (op <= OP_REMU);
  assign w_last      = (r_state == S_BUSY) && (r_cnt == '0);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign flags       = r_flags;
  assign o_state_dbg = (r_state == S_BUSY);

  // Single-cycle ops: adder with carry/overflow, logic, compares and shifts.
  always_comb begin
    w_sub        = (op == OP_SUB);
    w_bx         = w_sub ? ~b : b;
    w_sum        = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
    w_ovf        = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_simple_res = '0;
    w_simple_flg = 4'b0000;
    case (op)
      OP_ADD, OP_SUB: w_simple_res = w_sum[WIDTH-1:0];
      OP_AND:  w_simple_res = a & b;
      OP_OR:   w_simple_res = a | b;
      OP_XOR:  w_simple_res = a ^ b;
      OP_SLT:  w_simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_simple_res = a << b[SHW-1:0];
      OP_SRL:  w_simple_res = a >> b[SHW-1:0];
      OP_SRA:  w_simple_res = $signed(a) >>> b[SHW-1:0];
      default: w_simple_res = '0;
    endcase
    // Reserved codes leave all flags clear, including Z.
    if (op <= OP_SRA) begin
      w_simple_flg[3] = w_simple_res[WIDTH-1];
      w_simple_flg[2] = (w_simple_res == '0);
    end
    if (op == OP_ADD || op == OP_SUB) begin
      w_simple_flg[1] = w_sum[WIDTH];
      w_simple_flg[0] = w_ovf;
    end
  end

  // Operand signedness and magnitudes captured when an iterative op starts.
  always_comb begin
    w_a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
              (op == OP_DIV) || (op == OP_REM);
    w_b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    w_a_neg = w_a_sgn && a[WIDTH-1];
    w_b_neg = w_b_sgn && b[WIDTH-1];
    w_ma    = w_a_neg ? -a : a;
    w_mb    = w_b_neg ? -b : b;
  end

  // One multiply/divide iteration, plus sign fix-up applied on the last one.
  always_comb begin
    w_is_mul  = (r_op <= OP_MULHU);
    w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
    w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    w_div_tr  = w_div_sh - {1'b0, r_opnd};
    w_div_ge  = !w_div_tr[WIDTH];
    if (w_is_mul) begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_nxt = w_div_ge ? w_div_tr[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end
    w_prod = {w_hi_nxt, w_lo_nxt};
    if (r_neg_q) w_prod = -w_prod;
    w_quo = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_lo_nxt : w_lo_nxt);
    w_rem = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    case (r_op)
      OP_MUL:            w_iter_res = w_prod[WIDTH-1:0];
      OP_DIV, OP_DIVU:   w_iter_res = w_quo;
      OP_REM, OP_REMU:   w_iter_res = w_rem;
      default:           w_iter_res = w_prod[2*WIDTH-1:WIDTH];
    endcase
    w_iter_flg = {w_iter_res[WIDTH-1], (w_iter_res == '0), 2'b00};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: leave IDLE only for multiply/divide, return after last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_iter) w_state_nxt = S_BUSY;
      S_BUSY: if (r_cnt == '0)           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, iteration counter and registered result/flags/out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_is_iter) begin
        r_result    <= w_simple_res;
        r_flags     <= w_simple_flg;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_cnt   <= SHW'(WIDTH - 1);
        r_op    <= op;
        r_hi    <= '0;
        r_lo    <= (op <= OP_MULHU) ? w_mb : w_ma;
        r_opnd  <= (op <= OP_MULHU) ? w_ma : w_mb;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz    <= (b == '0);
      end else if (r_state == S_BUSY) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_result    <= w_iter_res;
          r_flags     <= w_iter_flg;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
